// File: rtl/alu32_seq.sv
// alu32_seq: issue/sequencing stage in front of the combinational 32-bit ALU.
// Optional out_ovf port is enabled by defining ALU32_SEQ_OVF_EN.
module alu32_seq #(
  parameter int WIDTH        = 32,
  parameter int SLT_TWO_PASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  // Request side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_fn,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  // ALU control and operands
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic             alu_less,
  output logic             alu_A_invert,
  output logic             alu_B_invert,
  output logic             alu_cin,
  output logic [1:0]       alu_operation,
  // ALU response
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_slt,
  // Result side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_err,
`ifdef ALU32_SEQ_OVF_EN
  output logic             out_ovf,
`endif
  output logic [1:0]       dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; once valid is raised, it and its payload hold until then.

  if (WIDTH != 32) begin : g_width_check
    $error("alu32_seq supports only WIDTH == 32");
  end

  localparam logic [3:0] FN_AND = 4'b0000;
  localparam logic [3:0] FN_OR  = 4'b0001;
  localparam logic [3:0] FN_ADD = 4'b0010;
  localparam logic [3:0] FN_SUB = 4'b0110;
  localparam logic [3:0] FN_SLT = 4'b0111;
  localparam logic [3:0] FN_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_SLT2 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic fn_legal(input logic [3:0] fn);
    case (fn)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_NOR: fn_legal = 1'b1;
      default:                                       fn_legal = 1'b0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       fn_q, fn_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             err_q, err_d;
  logic             set_q, set_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
`ifdef ALU32_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic add_ovf;
  logic sub_ovf;
  logic slt_set;

  // Signed overflow of the pass currently on the ALU, judged from the latched
  // operand signs and the sign of the returned sum.
  assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (alu_result[WIDTH-1] != a_q[WIDTH-1]);
  assign sub_ovf = (a_q[WIDTH-1] == ~b_q[WIDTH-1]) &&
                   (alu_result[WIDTH-1] != a_q[WIDTH-1]);
  assign slt_set = alu_slt ^ sub_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fn_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      err_q    <= 1'b0;
      set_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef ALU32_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      fn_q     <= fn_d;
      a_q      <= a_d;
      b_q      <= b_d;
      err_q    <= err_d;
      set_q    <= set_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef ALU32_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    fn_d     = fn_q;
    a_d      = a_q;
    b_d      = b_q;
    err_d    = err_q;
    set_d    = set_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef ALU32_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          fn_d    = in_fn;
          a_d     = in_a;
          b_d     = in_b;
          err_d   = !fn_legal(in_fn);
          set_d   = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        if (err_q) begin
          // Illegal code still spends one cycle here so latency matches legal ops.
          result_d = '0;
          cout_d   = 1'b0;
`ifdef ALU32_SEQ_OVF_EN
          ovf_d    = 1'b0;
`endif
        end else begin
          result_d = alu_result;
          cout_d   = alu_cout;
`ifdef ALU32_SEQ_OVF_EN
          if (fn_q == FN_ADD) begin
            ovf_d = add_ovf;
          end else if ((fn_q == FN_SUB) || (fn_q == FN_SLT)) begin
            ovf_d = sub_ovf;
          end else begin
            ovf_d = 1'b0;
          end
`endif
          if (fn_q == FN_SLT) begin
            set_d = slt_set;
            if (SLT_TWO_PASS != 0) begin
              state_d = S_SLT2;
            end else begin
              result_d = {{(WIDTH-1){1'b0}}, slt_set};
            end
          end
        end
      end
      S_SLT2: begin
        result_d = alu_result;
        cout_d   = alu_cout;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ALU controls depend only on state and latched registers.
  always_comb begin
    alu_src1      = a_q;
    alu_src2      = b_q;
    alu_A_invert  = fn_q[3];
    alu_B_invert  = fn_q[2];
    alu_cin       = fn_q[2];
    alu_operation = fn_q[1:0];
    alu_less      = 1'b0;
    if (fn_q == FN_SLT) begin
      if (state_q == S_EXEC) begin
        alu_operation = 2'b10;
      end else if (state_q == S_SLT2) begin
        alu_operation = 2'b11;
        alu_B_invert  = 1'b1;
        alu_cin       = 1'b1;
        alu_less      = set_q;
      end
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign out_result  = result_q;
  assign out_zero    = (result_q == '0);
  assign out_cout    = cout_q;
  assign out_err     = err_q;
`ifdef ALU32_SEQ_OVF_EN
  assign out_ovf     = ovf_q;
`endif
  assign dbg_state_o = state_q;

  a_no_overlap: assert property (@(posedge clk) disable iff (rst)
    !(in_ready && out_valid));
  a_hold_result: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_result)
                                   && $stable(out_cout) && $stable(out_err)));

endmodule

// File: tb/tb_alu32_seq.sv
// Bench for alu32_seq: behavioural ALU attached to the alu_* ports, random and
// directed requests, scoreboard queue checked by an independent monitor.
module tb_alu32_seq;

  localparam int W     = 32;
  localparam int SLT2P = 1;
  localparam int EW    = W + 3;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_fn;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] alu_src1, alu_src2;
  logic         alu_less, alu_A_invert, alu_B_invert, alu_cin;
  logic [1:0]   alu_operation;
  logic [W-1:0] alu_result;
  logic         alu_cout, alu_slt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_zero, out_cout, out_err;
`ifdef ALU32_SEQ_OVF_EN
  logic         out_ovf;
`endif
  logic [1:0]   dbg_state;

  alu32_seq #(.WIDTH(W), .SLT_TWO_PASS(SLT2P)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_fn(in_fn), .in_a(in_a), .in_b(in_b),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_less(alu_less),
    .alu_A_invert(alu_A_invert), .alu_B_invert(alu_B_invert), .alu_cin(alu_cin),
    .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_slt(alu_slt),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_cout(out_cout), .out_err(out_err),
`ifdef ALU32_SEQ_OVF_EN
    .out_ovf(out_ovf),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- external ALU ----------------
  always_comb begin : alu_model
    logic [W-1:0] ax, bx;
    logic [W:0]   s;
    ax = alu_A_invert ? ~alu_src1 : alu_src1;
    bx = alu_B_invert ? ~alu_src2 : alu_src2;
    s  = {1'b0, ax} + {1'b0, bx} + {{W{1'b0}}, alu_cin};
    case (alu_operation)
      2'b00:   alu_result = ax & bx;
      2'b01:   alu_result = ax | bx;
      2'b10:   alu_result = s[W-1:0];
      default: alu_result = {{(W-1){1'b0}}, alu_less};
    endcase
    alu_cout = s[W];
    alu_slt  = s[W-1];
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];   // {result, cout, err, ovf}
  int            due_q[$];   // cycle at which out_valid must first be seen
  int            vectors    = 0;
  int            miscompares = 0;
  bit            seen       = 1'b0;
  bit            rand_ready = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    if (act !== req) begin
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
      miscompares++;
    end
  endtask

  function automatic bit is_legal(input logic [3:0] fn);
    return (fn == 4'b0000) || (fn == 4'b0001) || (fn == 4'b0010) ||
           (fn == 4'b0110) || (fn == 4'b0111) || (fn == 4'b1100);
  endfunction

  function automatic bit sovf(input longint v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  // Reference: what the finished operation should report, from the op definitions.
  function automatic logic [EW-1:0] ref_model(input logic [3:0] fn, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [W-1:0] res;
    logic         cout, err, ovf;
    logic [W:0]   usum;
    longint       sa, sb;
    usum = {1'b0, a} + {1'b0, b};
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    err  = 1'b0;
    ovf  = 1'b0;
    case (fn)
      4'b0000: begin res = a & b;     cout = usum[W]; end
      4'b0001: begin res = a | b;     cout = usum[W]; end
      4'b0010: begin res = a + b;     cout = usum[W]; ovf = sovf(sa + sb); end
      4'b0110: begin res = a - b;     cout = (a >= b); ovf = sovf(sa - sb); end
      4'b0111: begin res = (sa < sb) ? 1 : 0; cout = (a >= b); ovf = sovf(sa - sb); end
      4'b1100: begin res = ~(a | b);  cout = !usum[W]; end  // ~a + ~b + 1 carries iff a+b does not
      default: begin res = '0;        cout = 1'b0; err = 1'b1; end
    endcase
    return {res, cout, err, ovf};
  endfunction

  // ---------------- drivers ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_fn = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Entered and left at a negedge.
  task automatic send_op(input logic [3:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    int lat;
    in_valid = 1'b1; in_fn = fn; in_a = a; in_b = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
      miscompares++;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = (is_legal(fn) && fn == 4'b0111 && SLT2P != 0) ? 3 : 2;
    exp_q.push_back(ref_model(fn, a, b));
    due_q.push_back(cyc + lat - 1);
    vectors++;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      miscompares++;
      exp_q.delete();
      due_q.delete();
    end
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output: out_valid=1 result=0x%08h, required no output", out_result);
        miscompares++;
      end else begin
        e = exp_q[0];
        chk("result", out_result, e[EW-1:3]);
        chk("zero",   {31'b0, out_zero}, {31'b0, (e[EW-1:3] == '0)});
        chk("cout",   {31'b0, out_cout}, {31'b0, e[2]});
        chk("err",    {31'b0, out_err},  {31'b0, e[1]});
`ifdef ALU32_SEQ_OVF_EN
        chk("ovf",    {31'b0, out_ovf},  {31'b0, e[0]});
`endif
        if (!seen) begin
          chk("latency_cycle", cyc, due_q[0]);
          seen = 1'b1;
        end
        if (out_ready) begin
          exp_q.delete(0);
          due_q.delete(0);
          seen = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] f;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready",   {31'b0, in_ready},  32'd1);
    chk("rst_out_valid",  {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result,         32'd0);
    chk("rst_out_zero",   {31'b0, out_zero},  32'd1);
    chk("rst_out_cout",   {31'b0, out_cout},  32'd0);
    chk("rst_out_err",    {31'b0, out_err},   32'd0);
    chk("rst_alu_less",   {31'b0, alu_less},  32'd0);
    chk("rst_alu_src1",   alu_src1,           32'd0);
    chk("rst_alu_src2",   alu_src2,           32'd0);

    // Directed operations
    send_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    send_op(4'b0110, 32'd5, 32'd5);
    send_op(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    send_op(4'b1100, 32'h0, 32'h0);
    send_op(4'b0111, 32'h8000_0000, 32'h0000_0001);
    send_op(4'b0111, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    send_op(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0);
    send_op(4'b0001, 32'hA5A5_0000, 32'h0000_5A5A);
    send_op(4'b0110, 32'h8000_0000, 32'h0000_0001);
    drain();

    // Backpressure: result must hold while ignored requests are presented
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    send_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0002);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_out_valid_seen", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_fn = 4'b0001; in_a = $urandom; in_b = $urandom;
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid_hold", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    drain();

    // Reset in the middle of an SLT: no result may ever appear for it
    in_valid = 1'b1; in_fn = 4'b0111; in_a = 32'h8000_0000; in_b = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (SLT2P != 0) begin
      chk("slt2_operation", {30'b0, alu_operation}, 32'd3);
      chk("slt2_b_invert",  {31'b0, alu_B_invert},  32'd1);
      chk("slt2_cin",       {31'b0, alu_cin},       32'd1);
      chk("slt2_less",      {31'b0, alu_less},      32'd1);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready",   {31'b0, in_ready},  32'd1);
    chk("midrst_out_valid",  {31'b0, out_valid}, 32'd0);
    chk("midrst_out_result", out_result,         32'd0);
    chk("midrst_out_zero",   {31'b0, out_zero},  32'd1);
    chk("midrst_alu_less",   {31'b0, alu_less},  32'd0);
    chk("midrst_alu_src1",   alu_src1,           32'd0);
    repeat (6) @(negedge clk);

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0: f = 4'b0000;
        1: f = 4'b0001;
        2: f = 4'b0010;
        3: f = 4'b0110;
        4: f = 4'b0111;
        5: f = 4'b1100;
        6: f = 4'b0111;
        default: begin
          f = 4'($urandom_range(0, 15));
          while (is_legal(f)) f = 4'($urandom_range(0, 15));
        end
      endcase
      if ($urandom_range(0, 7) == 0) begin
        in_a = rand_opnd();
        send_op(f, in_a, in_a);
      end else begin
        send_op(f, rand_opnd(), rand_opnd());
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
